// File: rtl/match_pkg.sv
// Shared types, constants and goal-geometry helpers for the soccer match sequencer.
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KICKOFF = 3'd1,
        ST_PLAY    = 3'd2,
        ST_GOAL    = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIDE_NONE  = 2'd0,
        SIDE_LEFT  = 2'd1,
        SIDE_RIGHT = 2'd2
    } side_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int DEF_FPS            = 60;
    localparam int DEF_MATCH_SECS     = 90;
    localparam int DEF_KICKOFF_FRAMES = 120;
    localparam int DEF_GOAL_FRAMES    = 90;
    localparam int DEF_WIN_SCORE      = 5;
    localparam int DEF_PLAY_STEP      = 2;

    localparam logic [10:0] GOAL_LEFT_X  = 11'd8;
    localparam logic [10:0] GOAL_RIGHT_X = 11'd631;
    localparam logic [10:0] GOAL_Y_MIN   = 11'd180;
    localparam logic [10:0] GOAL_Y_MAX   = 11'd300;

    // 11-bit sums keep X + radius from wrapping; left wins when both lines are crossed.
    function automatic side_e goal_side(input logic [9:0] x, input logic [9:0] y,
                                        input logic [9:0] s);
        logic [10:0] x11;
        logic [10:0] y11;
        logic [10:0] s11;
        logic        mouth;
        side_e       side;
        x11   = {1'b0, x};
        y11   = {1'b0, y};
        s11   = {1'b0, s};
        mouth = (y11 >= GOAL_Y_MIN) && (y11 <= GOAL_Y_MAX);
        side  = SIDE_NONE;
        if (mouth && (x11 <= GOAL_LEFT_X + s11)) begin
            side = SIDE_LEFT;
        end else if (mouth && (x11 + s11 >= GOAL_RIGHT_X)) begin
            side = SIDE_RIGHT;
        end
        return side;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    function automatic logic [1:0] winner_of(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] w;
        if (a > b) begin
            w = WIN_P1;
        end else if (b > a) begin
            w = WIN_P2;
        end else begin
            w = WIN_DRAW;
        end
        return w;
    endfunction

endpackage

// File: rtl/match_timer.sv
// Match countdown: frame-within-second counter and seconds remaining, advancing only while run is high.
module match_timer
    import match_pkg::*;
#(
    parameter int FPS        = DEF_FPS,
    parameter int MATCH_SECS = DEF_MATCH_SECS
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       run,
    input  logic       load,
    output logic [7:0] secs_left,
    output logic       tick_sec
);

    localparam int            FW         = (FPS > 1) ? $clog2(FPS) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FPS - 1);
    localparam logic [7:0]    SECS_INIT  = 8'(MATCH_SECS);

    logic [FW-1:0] frame_q, frame_d;
    logic [7:0]    secs_q, secs_d;

    assign tick_sec  = run && (frame_q == FRAME_LAST);
    assign secs_left = secs_q;

    always_comb begin
        frame_d = frame_q;
        secs_d  = secs_q;
        if (load) begin
            frame_d = '0;
            secs_d  = SECS_INIT;
        end else if (run) begin
            if (tick_sec) begin
                frame_d = '0;
                if (secs_q != 8'd0) begin
                    secs_d = secs_q - 8'd1;
                end
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            frame_q <= '0;
            secs_q  <= SECS_INIT;
        end else begin
            frame_q <= frame_d;
            secs_q  <= secs_d;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Frame-rate match sequencer: state, goal detection, scores, winner and motion controls.
module match_ctrl
    import match_pkg::*;
#(
    parameter int FPS            = DEF_FPS,
    parameter int MATCH_SECS     = DEF_MATCH_SECS,
    parameter int KICKOFF_FRAMES = DEF_KICKOFF_FRAMES,
    parameter int GOAL_FRAMES    = DEF_GOAL_FRAMES,
    parameter int WIN_SCORE      = DEF_WIN_SCORE,
    parameter int PLAY_STEP      = DEF_PLAY_STEP
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic       centerPlayer,
    output logic [9:0] step,
    output logic       frictionFactor,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [7:0] secs_left,
    output logic [2:0] state_o,
    output logic [1:0] winner
);

    localparam logic [7:0] KICK_LAST = 8'(KICKOFF_FRAMES - 1);
    localparam logic [7:0] GOAL_LAST = 8'(GOAL_FRAMES - 1);
    localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
    localparam logic [9:0] STEP_VAL  = 10'(PLAY_STEP);

    state_e     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] winner_q, winner_d;
    logic       center_q, center_d;
    logic [9:0] step_q, step_d;
    logic       fric_q, fric_d;

    side_e      side;
    logic       timer_load;
    logic       timer_run;
    logic       tick_sec;

    assign side      = goal_side(BallX, BallY, BallS);
    assign timer_run = (state_q == ST_PLAY);

    match_timer #(
        .FPS        (FPS),
        .MATCH_SECS (MATCH_SECS)
    ) u_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .run       (timer_run),
        .load      (timer_load),
        .secs_left (secs_left),
        .tick_sec  (tick_sec)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WIN_NONE;
            center_q <= 1'b1;
            step_q   <= '0;
            fric_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            center_q <= center_d;
            step_q   <= step_d;
            fric_q   <= fric_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        winner_d   = winner_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d    = ST_KICKOFF;
                    phase_d    = KICK_LAST;
                    score1_d   = '0;
                    score2_d   = '0;
                    winner_d   = WIN_NONE;
                    timer_load = 1'b1;
                end
            end
            ST_KICKOFF: begin
                if (phase_q == 8'd0) begin
                    state_d = ST_PLAY;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            ST_PLAY: begin
                if (side == SIDE_LEFT) begin
                    score2_d = sat_inc(score2_q);
                end else if (side == SIDE_RIGHT) begin
                    score1_d = sat_inc(score1_q);
                end
                // The last second expiring overrides the goal celebration.
                if (tick_sec && (secs_left == 8'd1)) begin
                    state_d = ST_OVER;
                end else if (side != SIDE_NONE) begin
                    state_d = ST_GOAL;
                    phase_d = GOAL_LAST;
                end
            end
            ST_GOAL: begin
                if (phase_q == 8'd0) begin
                    if ((score1_q >= WIN_LIM) || (score2_q >= WIN_LIM)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_KICKOFF;
                        phase_d = KICK_LAST;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
            winner_d = winner_of(score1_d, score2_d);
        end
    end

    always_comb begin
        center_d = 1'b1;
        step_d   = '0;
        fric_d   = 1'b0;
        case (state_d)
            ST_PLAY: begin
                center_d = 1'b0;
                step_d   = STEP_VAL;
                fric_d   = 1'b1;
            end
            ST_GOAL: begin
                center_d = 1'b0;
                fric_d   = 1'b1;
            end
            default: begin
                center_d = 1'b1;
            end
        endcase
    end

    assign centerPlayer   = center_q;
    assign step           = step_q;
    assign frictionFactor = fric_q;
    assign score1         = score1_q;
    assign score2         = score2_q;
    assign state_o        = state_q;
    assign winner         = winner_q;

endmodule
